// File: rtl/rmt_ctrl_pkg.sv
// rmt_ctrl_pkg: shared state encoding and widths for the control-packet path
package rmt_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, SEND, DRAIN, GAP} ctrl_state_e;
  localparam int CTRL_DATA_W = 512;
  localparam int CTRL_USER_W = 128;
  localparam int TRUNC_W     = 16;
  localparam int GAP_W       = 8;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: rotating-priority pick of the first requester after last_grant
module rr_arbiter #(
  parameter int NUM_SRC = 2,
  localparam int IW = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic [NUM_SRC-1:0] grant_onehot,
  output logic [IW-1:0]      grant_idx
);
  logic          found;
  logic [IW-1:0] cand;
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    found        = 1'b0;
    cand         = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = IW'((int'(last_grant) + k) % NUM_SRC);
      if (!found && req[cand]) begin
        found              = 1'b1;
        grant_onehot[cand] = 1'b1;
        grant_idx          = cand;
      end
    end
  end
endmodule

// File: rtl/ctrl_pkt_arbiter.sv
// ctrl_pkt_arbiter: packet-atomic round-robin merge of control sources with a post-packet idle gap
module ctrl_pkt_arbiter
  import rmt_ctrl_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = CTRL_DATA_W,
  parameter int C_S_AXIS_TUSER_WIDTH = CTRL_USER_W,
  parameter int NUM_SRC              = 2,
  parameter int GAP_CYCLES           = 4,
  parameter int MAX_BEATS            = 16,
  localparam int DW = C_S_AXIS_DATA_WIDTH,
  localparam int KW = C_S_AXIS_DATA_WIDTH / 8,
  localparam int UW = C_S_AXIS_TUSER_WIDTH,
  localparam int IW = $clog2(NUM_SRC)
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic [NUM_SRC*DW-1:0] s_axis_tdata,
  input  logic [NUM_SRC*KW-1:0] s_axis_tkeep,
  input  logic [NUM_SRC*UW-1:0] s_axis_tuser,
  input  logic [NUM_SRC-1:0]    s_axis_tvalid,
  input  logic [NUM_SRC-1:0]    s_axis_tlast,
  output logic [NUM_SRC-1:0]    s_axis_tready,
  output logic [DW-1:0]         c_m_axis_tdata,
  output logic [KW-1:0]         c_m_axis_tkeep,
  output logic [UW-1:0]         c_m_axis_tuser,
  output logic                  c_m_axis_tvalid,
  output logic                  c_m_axis_tlast,
  output logic [IW-1:0]         grant_idx,
  output logic [TRUNC_W-1:0]    trunc_cnt
);
  localparam int BW = $clog2(MAX_BEATS + 1);

  ctrl_state_e          state_q, state_d, after_pkt;
  logic [IW-1:0]        grant_q, grant_d, last_q, last_d, rr_idx;
  logic [NUM_SRC-1:0]   oh_q, oh_d, rr_oh;
  logic [BW-1:0]        beat_q, beat_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [TRUNC_W-1:0]   trunc_q, trunc_d;
  logic [DW-1:0]        data_q, data_d;
  logic [KW-1:0]        keep_q, keep_d;
  logic [UW-1:0]        user_q, user_d;
  logic                 valid_q, valid_d, tlast_q, tlast_d;
  logic                 acc, sel_last, at_max;

  rr_arbiter #(.NUM_SRC(NUM_SRC)) u_rr (
    .req          (s_axis_tvalid),
    .last_grant   (last_q),
    .grant_onehot (rr_oh),
    .grant_idx    (rr_idx)
  );

  assign s_axis_tready = (state_q == SEND || state_q == DRAIN) ? oh_q : '0;
  assign acc           = |(s_axis_tvalid & s_axis_tready);
  assign sel_last      = s_axis_tlast[grant_q];
  assign at_max        = beat_q == BW'(MAX_BEATS - 1);
  assign after_pkt     = (GAP_CYCLES == 0) ? IDLE : GAP;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    oh_d    = oh_q;
    beat_d  = beat_q;
    gap_d   = gap_q;
    trunc_d = trunc_q;
    data_d  = data_q;
    keep_d  = keep_q;
    user_d  = user_q;
    valid_d = 1'b0;
    tlast_d = 1'b0;
    case (state_q)
      IDLE: if (|s_axis_tvalid) begin
        state_d = SEND;
        grant_d = rr_idx;
        last_d  = rr_idx;
        oh_d    = rr_oh;
        beat_d  = '0;
      end
      SEND: if (acc) begin
        valid_d = 1'b1;
        data_d  = s_axis_tdata[grant_q*DW +: DW];
        keep_d  = s_axis_tkeep[grant_q*KW +: KW];
        user_d  = s_axis_tuser[grant_q*UW +: UW];
        tlast_d = sel_last | at_max;
        beat_d  = beat_q + 1'b1;
        if (sel_last) begin
          state_d = after_pkt;
          gap_d   = GAP_W'(GAP_CYCLES);
        end else if (at_max) begin
          state_d = DRAIN;
          trunc_d = (&trunc_q) ? trunc_q : trunc_q + 1'b1;
        end
      end
      // the overlong tail is swallowed so the source can move on to its next packet
      DRAIN: if (acc && sel_last) begin
        state_d = after_pkt;
        gap_d   = GAP_W'(GAP_CYCLES);
      end
      GAP: begin
        gap_d   = gap_q - 1'b1;
        state_d = (gap_q == GAP_W'(1)) ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(NUM_SRC - 1);
      oh_q    <= '0;
      beat_q  <= '0;
      gap_q   <= '0;
      trunc_q <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      user_q  <= '0;
      valid_q <= 1'b0;
      tlast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      oh_q    <= oh_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
      trunc_q <= trunc_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      user_q  <= user_d;
      valid_q <= valid_d;
      tlast_q <= tlast_d;
    end
  end

  assign c_m_axis_tdata  = data_q;
  assign c_m_axis_tkeep  = keep_q;
  assign c_m_axis_tuser  = user_q;
  assign c_m_axis_tvalid = valid_q;
  assign c_m_axis_tlast  = tlast_q;
  assign grant_idx       = grant_q;
  assign trunc_cnt       = trunc_q;
endmodule

// File: doc/ctrl_pkt_arbiter.md
# ctrl_pkt_arbiter

Packet-atomic round-robin arbiter that merges NUM_SRC control-packet sources onto the single control-path stream entering the parser/stage/deparser configuration chain. Each source is an AXI-Stream slave with backpressure. The output chain has no tready, so the block never stalls mid-packet on the output side. After every packet it inserts a fixed idle gap so downstream stages can commit table writes before the next control packet arrives.

## Interface
- C_S_AXIS_DATA_WIDTH, 512: tdata width per source and on the output.
- C_S_AXIS_TUSER_WIDTH, 128: tuser width.
- NUM_SRC, 2: number of control sources (2–8).
- GAP_CYCLES, 4: idle cycles forced after each output tlast (0–255).
- MAX_BEATS, 16: longest legal control packet, in beats.

Ports:
- clk  in  1  axis clock.
- aresetn  in  1  reset; asynchronous, active-low.
- s_axis_tdata  in  NUM_SRC*C_S_AXIS_DATA_WIDTH  source data, source i at slice i.
- s_axis_tkeep  in  NUM_SRC*C_S_AXIS_DATA_WIDTH/8  source keep.
- s_axis_tuser  in  NUM_SRC*C_S_AXIS_TUSER_WIDTH  source user.
- s_axis_tvalid  in  NUM_SRC  per-source valid.
- s_axis_tlast  in  NUM_SRC  per-source last.
- s_axis_tready  out  NUM_SRC  per-source ready; one-hot or zero.
- c_m_axis_tdata  out  C_S_AXIS_DATA_WIDTH  merged control data.
- c_m_axis_tkeep  out  C_S_AXIS_DATA_WIDTH/8  merged keep.
- c_m_axis_tuser  out  C_S_AXIS_TUSER_WIDTH  merged user.
- c_m_axis_tvalid  out  1  merged valid; no ready.
- c_m_axis_tlast  out  1  merged last.
- grant_idx  out  $clog2(NUM_SRC)  source currently or last granted.
- trunc_cnt  out  16  count of packets truncated at MAX_BEATS; saturates.

## Operation
- States: IDLE, SEND, DRAIN, GAP.
- **IDLE**
  - All tready are 0.
  - If any tvalid is high, select the first valid source scanning from last_grant+1 with wrap (round-robin), register it as grant, and go to SEND.
- **SEND**
  - s_axis_tready[grant]=1; all others 0.
  - Each accepted beat (tvalid & tready) is registered to the c_m outputs with c_m_axis_tvalid=1.
  - A tvalid bubble produces an output bubble; the grant is held.
  - Beat counter increments per accepted beat.
  - On an accepted tlast, go to GAP, or to IDLE if GAP_CYCLES=0.
  - If the MAX_BEATS-th beat is accepted without tlast, force c_m_axis_tlast=1 on it, increment trunc_cnt, and go to DRAIN.
- **DRAIN**
  - tready[grant]=1; accepted beats are discarded (c_m_axis_tvalid=0).
  - On an accepted tlast, go to GAP or IDLE, as after SEND.
- **GAP**
  - Gap counter loads GAP_CYCLES on entry; tready all 0; decrement each cycle; at 1 → IDLE.
- Grant changes only in IDLE. Sources that are not granted see tready=0 and must hold their data.
- Simultaneous requests are resolved only by the round-robin pointer; a source holding tvalid continuously is served at least once every NUM_SRC packets.

## Timing
- Output is registered: an input beat accepted in cycle t appears on c_m_* in cycle t+1.
- Arbitration: tvalid first seen in IDLE at cycle t → grant registered and tready high at t+1 → first output beat at t+2 (minimum).
- Back-to-back packets from any sources are separated by at least GAP_CYCLES+1 cycles of c_m_axis_tvalid=0 (GAP plus the IDLE arbitration cycle).
- Reset values:
  - state=IDLE; last_grant=NUM_SRC-1, so source 0 wins first; grant_idx=0.
  - All tready and c_m_* outputs are 0; counters are 0.
- Reset asserted mid-packet clears the outputs asynchronously. The truncated packet is not terminated with tlast. Downstream stages discard partial packets by their own reset.
- c_m_axis_tdata/tkeep/tuser are don't-care when tvalid=0; the bench must not check them then.

## Structure
- Shared package rmt_ctrl_pkg holds:
  - the state enum (IDLE/SEND/DRAIN/GAP);
  - the control-packet width constants;
  - the trunc_cnt width.
- One sub-module, rr_arbiter: a combinational rotate-priority encoder with inputs req[NUM_SRC] and last_grant, and outputs grant_onehot and grant_idx.
- The FSM, counters, and output registers live in ctrl_pkt_arbiter.

## Test plan
- **Single source:** source 0 sends 3 beats with tlast on beat 3 → c_m valid 3 cycles starting 2 cycles after the first tvalid, tlast on the 3rd, data unchanged; then ≥5 idle cycles (GAP_CYCLES=4).
- **Contention:** after reset, sources 0 and 1 both assert a 2-beat packet in the same cycle → source 0's packet, 5 idle cycles, then source 1's packet; grant_idx reads 0 then 1.
- **Fairness:** source 1 streams continuously while source 0 sends one packet → at most one source-1 packet precedes source 0's.
- **Mid-packet bubble:** a 4-beat packet with tvalid low for 2 cycles after beat 2 → output shows 2 bubble cycles, grant holds, and a competing source is not granted.
- **Truncation:** a 20-beat packet with MAX_BEATS=16 → 16 output beats, tlast forced on beat 16, beats 17–20 consumed with no output, trunc_cnt=1.
- **Reset mid-packet:** aresetn low during beat 2 → all outputs 0 immediately; after release, the first grant goes to source 0.
